// File: rtl/scr1_bpu_pkg.sv
// Shared types and saturating-counter helpers for the SCR1 branch predictor.
package scr1_bpu_pkg;

    localparam int unsigned SCR1_XLEN = 32;

    typedef enum logic {
        SCR1_BPU_BIMODAL = 1'b0,
        SCR1_BPU_GSHARE  = 1'b1
    } bpu_mode_e;

    // Tag is held zero-extended to XLEN so the entry type does not depend on BTB depth.
    typedef struct packed {
        logic                 valid;
        logic [SCR1_XLEN-1:0] tag;
        logic [SCR1_XLEN-1:0] target;
    } btb_entry_t;

    function automatic logic [3:0] sat_cnt_max(input int unsigned width);
        return 4'((32'd1 << width) - 32'd1);
    endfunction

    // Weakly not-taken: the largest value whose MSB is still clear.
    function automatic logic [3:0] sat_cnt_reset(input int unsigned width);
        return 4'((32'd1 << (width - 32'd1)) - 32'd1);
    endfunction

    function automatic logic [3:0] sat_cnt_next(input logic [3:0] cnt,
                                                input logic taken,
                                                input int unsigned width);
        logic [3:0] max_val;
        max_val = sat_cnt_max(width);
        if (taken) begin
            return (cnt == max_val) ? cnt : cnt + 4'd1;
        end
        return (cnt == 4'd0) ? cnt : cnt - 4'd1;
    endfunction

endpackage

// File: rtl/scr1_bpu_pht.sv
// Pattern history table: saturating counters with a registered read port and a
// read-modify-write training port; a colliding read sees the pre-update value.
module scr1_bpu_pht
    import scr1_bpu_pkg::*;
#(
    parameter int unsigned PHT_DEPTH = 256,
    parameter int unsigned CNT_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_en,
    input  logic [$clog2(PHT_DEPTH)-1:0] rd_idx,
    output logic [CNT_W-1:0]             rd_cnt,
    input  logic                         upd_en,
    input  logic [$clog2(PHT_DEPTH)-1:0] upd_idx,
    input  logic                         upd_taken
);

    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(sat_cnt_reset(CNT_W));

    logic [CNT_W-1:0] cnt [PHT_DEPTH];
    logic [CNT_W-1:0] upd_next;

    assign upd_next = CNT_W'(sat_cnt_next(4'(cnt[upd_idx]), upd_taken, CNT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                cnt[i] <= CNT_RST;
            end
            rd_cnt <= CNT_RST;
        end else begin
            if (rd_en) begin
                rd_cnt <= cnt[rd_idx];
            end
            if (upd_en) begin
                cnt[upd_idx] <= upd_next;
            end
        end
    end

endmodule

// File: rtl/scr1_bpu_gshare.sv
// SCR1 branch predictor: direct-mapped tagged BTB plus bimodal/gshare PHT,
// with a speculative global history register restored on mispredict.
module scr1_bpu_gshare
    import scr1_bpu_pkg::*;
#(
    parameter int unsigned BTB_DEPTH = 32,
    parameter int unsigned PHT_DEPTH = 256,
    parameter int unsigned HIST_W    = 8,
    parameter int unsigned CNT_W     = 2,
    parameter bpu_mode_e   MODE      = SCR1_BPU_GSHARE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ifu2bpu_lookup_req_i,
    input  logic [SCR1_XLEN-1:0] ifu2bpu_pc_i,
    output logic                 bpu2ifu_valid_o,
    output logic                 bpu2ifu_prediction_o,
    output logic [SCR1_XLEN-1:0] bpu2ifu_target_o,
    output logic [HIST_W-1:0]    bpu2ifu_ghr_o,
    input  logic                 exu2bpu_upd_i,
    input  logic [SCR1_XLEN-1:0] exu2bpu_upd_pc_i,
    input  logic                 exu2bpu_upd_taken_i,
    input  logic [SCR1_XLEN-1:0] exu2bpu_upd_target_i,
    input  logic [HIST_W-1:0]    exu2bpu_upd_ghr_i,
    input  logic                 exu2bpu_upd_mispred_i
);

    localparam int unsigned BTB_IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned IDX_W     = $clog2(PHT_DEPTH);
    localparam int unsigned TAG_SHIFT = 2 + BTB_IDX_W;

    btb_entry_t btb [BTB_DEPTH];

    logic [HIST_W-1:0]    ghr;
    logic [IDX_W-1:0]     lookup_idx;
    logic [IDX_W-1:0]     upd_idx;
    logic [BTB_IDX_W-1:0] lookup_bidx;
    logic [BTB_IDX_W-1:0] upd_bidx;
    logic [SCR1_XLEN-1:0] lookup_tag;
    logic [SCR1_XLEN-1:0] upd_tag;
    btb_entry_t           lookup_entry;
    logic                 lookup_hit;
    logic [CNT_W-1:0]     lookup_cnt;

    logic                 valid_q;
    logic                 hit_q;
    logic [SCR1_XLEN-1:0] target_q;
    logic [HIST_W-1:0]    ghr_q;
    logic                 prediction;

    // In gshare mode the history is zero-extended and folded into the low PC index bits.
    always_comb begin
        lookup_idx = ifu2bpu_pc_i[2 +: IDX_W];
        upd_idx    = exu2bpu_upd_pc_i[2 +: IDX_W];
        if (MODE == SCR1_BPU_GSHARE) begin
            lookup_idx = lookup_idx ^ IDX_W'(ghr);
            upd_idx    = upd_idx ^ IDX_W'(exu2bpu_upd_ghr_i);
        end
        lookup_bidx  = ifu2bpu_pc_i[2 +: BTB_IDX_W];
        upd_bidx     = exu2bpu_upd_pc_i[2 +: BTB_IDX_W];
        lookup_tag   = ifu2bpu_pc_i >> TAG_SHIFT;
        upd_tag      = exu2bpu_upd_pc_i >> TAG_SHIFT;
        lookup_entry = btb[lookup_bidx];
        lookup_hit   = lookup_entry.valid && (lookup_entry.tag == lookup_tag);
    end

    scr1_bpu_pht #(
        .PHT_DEPTH (PHT_DEPTH),
        .CNT_W     (CNT_W)
    ) i_pht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (ifu2bpu_lookup_req_i),
        .rd_idx    (lookup_idx),
        .rd_cnt    (lookup_cnt),
        .upd_en    (exu2bpu_upd_i),
        .upd_idx   (upd_idx),
        .upd_taken (exu2bpu_upd_taken_i)
    );

    // Only taken branches allocate; a not-taken resolution leaves the entry alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb[i] <= '0;
            end
        end else if (exu2bpu_upd_i && exu2bpu_upd_taken_i) begin
            btb[upd_bidx] <= '{valid: 1'b1, tag: upd_tag, target: exu2bpu_upd_target_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
            target_q <= '0;
            ghr_q    <= '0;
        end else begin
            valid_q <= ifu2bpu_lookup_req_i;
            if (ifu2bpu_lookup_req_i) begin
                hit_q    <= lookup_hit;
                target_q <= lookup_entry.target;
                ghr_q    <= ghr;
            end
        end
    end

    assign prediction = hit_q & lookup_cnt[CNT_W-1];

    // The speculative shift lands while a hitting result is presented; a mispredict
    // restore in that same cycle takes priority and the shift is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (exu2bpu_upd_i && exu2bpu_upd_mispred_i) begin
            ghr <= HIST_W'({exu2bpu_upd_ghr_i, exu2bpu_upd_taken_i});
        end else if (valid_q && hit_q) begin
            ghr <= HIST_W'({ghr, prediction});
        end
    end

    assign bpu2ifu_valid_o      = valid_q;
    assign bpu2ifu_prediction_o = prediction;
    assign bpu2ifu_target_o     = prediction ? target_q : '0;
    assign bpu2ifu_ghr_o        = ghr_q;

endmodule

// File: tb/tb_scr1_bpu_gshare.sv
// Bench for scr1_bpu_gshare: a bimodal and a gshare instance driven side by side
// and compared each cycle against an array-based predictor model.
module tb_scr1_bpu_gshare;
    import scr1_bpu_pkg::*;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        upd;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic [7:0]  ughr;
        logic        mis;
        logic        ev;
        logic        ep;
        logic [31:0] et;
        logic [7:0]  eg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req  [2];
    logic [31:0] pc   [2];
    logic        upd  [2];
    logic [31:0] upc  [2];
    logic        tk   [2];
    logic [31:0] utgt [2];
    logic [7:0]  ughr [2];
    logic        mis  [2];

    logic        v_o [2];
    logic        p_o [2];
    logic [31:0] t_o [2];
    logic [7:0]  g_o [2];
    logic [7:0]  ghr_o0;
    logic [3:0]  ghr_o1;
    assign g_o[0] = ghr_o0;
    assign g_o[1] = {4'h0, ghr_o1};

    int checks = 0;
    int errors = 0;

    int mode_of [2] = '{0, 1};
    int hist_of [2] = '{8, 4};

    int          m_pht  [2][256];
    bit          m_bv   [2][32];
    logic [31:0] m_btag [2][32];
    logic [31:0] m_btgt [2][32];
    int unsigned m_ghr  [2];
    bit          e_valid [2];
    bit          e_hit   [2];
    bit          e_pred  [2];
    logic [31:0] e_tgt   [2];
    int unsigned e_ghr   [2];

    vec_t vecs [27];

    scr1_bpu_gshare #(.HIST_W(8), .CNT_W(2), .MODE(SCR1_BPU_BIMODAL)) dut_bim (
        .clk(clk), .rst_n(rst_n),
        .ifu2bpu_lookup_req_i(req[0]), .ifu2bpu_pc_i(pc[0]),
        .bpu2ifu_valid_o(v_o[0]), .bpu2ifu_prediction_o(p_o[0]),
        .bpu2ifu_target_o(t_o[0]), .bpu2ifu_ghr_o(ghr_o0),
        .exu2bpu_upd_i(upd[0]), .exu2bpu_upd_pc_i(upc[0]),
        .exu2bpu_upd_taken_i(tk[0]), .exu2bpu_upd_target_i(utgt[0]),
        .exu2bpu_upd_ghr_i(ughr[0]), .exu2bpu_upd_mispred_i(mis[0])
    );

    scr1_bpu_gshare #(.HIST_W(4), .CNT_W(2), .MODE(SCR1_BPU_GSHARE)) dut_gsh (
        .clk(clk), .rst_n(rst_n),
        .ifu2bpu_lookup_req_i(req[1]), .ifu2bpu_pc_i(pc[1]),
        .bpu2ifu_valid_o(v_o[1]), .bpu2ifu_prediction_o(p_o[1]),
        .bpu2ifu_target_o(t_o[1]), .bpu2ifu_ghr_o(ghr_o1),
        .exu2bpu_upd_i(upd[1]), .exu2bpu_upd_pc_i(upc[1]),
        .exu2bpu_upd_taken_i(tk[1]), .exu2bpu_upd_target_i(utgt[1]),
        .exu2bpu_upd_ghr_i(ughr[1][3:0]), .exu2bpu_upd_mispred_i(mis[1])
    );

    function automatic vec_t mk(input int r, input int p, input int u, input int up,
                                input int t, input int tg, input int gh, input int m,
                                input int ev, input int ep, input int et, input int eg);
        vec_t v;
        v.req = (r != 0);  v.pc = 32'(p);   v.upd = (u != 0); v.upc = 32'(up);
        v.tk = (t != 0);   v.tgt = 32'(tg); v.ughr = 8'(gh);  v.mis = (m != 0);
        v.ev = (ev != 0);  v.ep = (ep != 0); v.et = 32'(et);  v.eg = 8'(eg);
        return v;
    endfunction

    task automatic check_output(input string name, input int id,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s #%0d actual=0x%0h required=0x%0h", name, id, act, exp);
        end
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; pc[d] = '0; upd[d] = 1'b0; upc[d] = '0;
            tk[d] = 1'b0; utgt[d] = '0; ughr[d] = '0; mis[d] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) m_pht[d][i] = 1;
            for (int i = 0; i < 32; i++) begin
                m_bv[d][i] = 1'b0; m_btag[d][i] = '0; m_btgt[d][i] = '0;
            end
            m_ghr[d] = 0; e_valid[d] = 1'b0; e_hit[d] = 1'b0;
            e_pred[d] = 1'b0; e_tgt[d] = '0; e_ghr[d] = 0;
        end
    endtask

    // Lookups see the state before this cycle's training; history follows the result shown now.
    task automatic model_step();
        int unsigned mask, ng, pi, bi, ui, ub;
        for (int d = 0; d < 2; d++) begin
            mask = (32'd1 << hist_of[d]) - 32'd1;
            ng = m_ghr[d];
            if (upd[d] && mis[d]) ng = ((32'(ughr[d]) << 1) | 32'(tk[d])) & mask;
            else if (e_valid[d] && e_hit[d]) ng = ((m_ghr[d] << 1) | 32'(e_pred[d])) & mask;
            if (req[d]) begin
                pi = ((pc[d] >> 2) % 256) ^ ((mode_of[d] != 0) ? m_ghr[d] : 0);
                bi = (pc[d] >> 2) % 32;
                e_valid[d] = 1'b1;
                e_hit[d]   = m_bv[d][bi] && (m_btag[d][bi] == (pc[d] >> 7));
                e_pred[d]  = e_hit[d] && (m_pht[d][pi] >= 2);
                e_tgt[d]   = e_pred[d] ? m_btgt[d][bi] : 32'h0;
                e_ghr[d]   = m_ghr[d];
            end else begin
                e_valid[d] = 1'b0;
            end
            if (upd[d]) begin
                ui = ((upc[d] >> 2) % 256) ^ ((mode_of[d] != 0) ? (32'(ughr[d]) & mask) : 0);
                if (tk[d]) m_pht[d][ui] = (m_pht[d][ui] < 3) ? m_pht[d][ui] + 1 : 3;
                else       m_pht[d][ui] = (m_pht[d][ui] > 0) ? m_pht[d][ui] - 1 : 0;
                if (tk[d]) begin
                    ub = (upc[d] >> 2) % 32;
                    m_bv[d][ub] = 1'b1; m_btag[d][ub] = upc[d] >> 7; m_btgt[d][ub] = utgt[d];
                end
            end
            m_ghr[d] = ng;
        end
    endtask

    task automatic apply_stimulus();
        model_step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_output("model_valid", d, 32'(v_o[d]), 32'(e_valid[d]));
            check_output("model_pred", d, 32'(p_o[d]), 32'(e_pred[d]));
            check_output("model_target", d, t_o[d], e_tgt[d]);
            check_output("model_ghr", d, 32'(g_o[d]), e_ghr[d]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          actual, pred_seen;
        logic [7:0]  snap;

        // Bimodal directed table: training, saturation, aliasing, same-cycle collision, restore.
        vecs[0]  = mk(1, 'h100,  0, 0,      0, 0,      0,    0, 1, 0, 0,      0);
        vecs[1]  = mk(0, 0,      1, 'h200,  1, 'h400,  0,    0, 0, 0, 0,      0);
        vecs[2]  = mk(0, 0,      1, 'h200,  1, 'h400,  0,    0, 0, 0, 0,      0);
        vecs[3]  = mk(1, 'h200,  0, 0,      0, 0,      0,    0, 1, 1, 'h400,  0);
        vecs[4]  = mk(0, 0,      0, 0,      0, 0,      0,    0, 0, 1, 'h400,  0);
        vecs[5]  = mk(0, 0,      1, 'h200,  0, 0,      0,    0, 0, 1, 'h400,  0);
        vecs[6]  = mk(0, 0,      1, 'h200,  0, 0,      0,    0, 0, 1, 'h400,  0);
        vecs[7]  = mk(0, 0,      1, 'h200,  0, 0,      0,    0, 0, 1, 'h400,  0);
        vecs[8]  = mk(1, 'h200,  0, 0,      0, 0,      0,    0, 1, 0, 0,      1);
        vecs[9]  = mk(0, 0,      0, 0,      0, 0,      0,    0, 0, 0, 0,      1);
        vecs[10] = mk(0, 0,      1, 'h240,  1, 'h600,  0,    0, 0, 0, 0,      1);
        vecs[11] = mk(0, 0,      1, 'h240,  1, 'h600,  0,    0, 0, 0, 0,      1);
        vecs[12] = mk(0, 0,      1, 'h240,  1, 'h600,  0,    0, 0, 0, 0,      1);
        vecs[13] = mk(0, 0,      1, 'h240,  1, 'h600,  0,    0, 0, 0, 0,      1);
        vecs[14] = mk(0, 0,      1, 'h240,  1, 'h600,  0,    0, 0, 0, 0,      1);
        vecs[15] = mk(0, 0,      1, 'h240,  0, 0,      0,    0, 0, 0, 0,      1);
        vecs[16] = mk(1, 'h240,  0, 0,      0, 0,      0,    0, 1, 1, 'h600,  2);
        vecs[17] = mk(0, 0,      1, 'h240,  0, 0,      0,    0, 0, 1, 'h600,  2);
        vecs[18] = mk(0, 0,      1, 'h240,  0, 0,      0,    0, 0, 1, 'h600,  2);
        vecs[19] = mk(1, 'h240,  0, 0,      0, 0,      0,    0, 1, 0, 0,      5);
        vecs[20] = mk(0, 0,      1, 'h80,   1, 'h900,  0,    0, 0, 0, 0,      5);
        vecs[21] = mk(1, 'h1080, 0, 0,      0, 0,      0,    0, 1, 0, 0,      'h0a);
        vecs[22] = mk(1, 'h80,   1, 'h80,   1, 'ha00,  0,    0, 1, 1, 'h900,  'h0a);
        vecs[23] = mk(1, 'h80,   0, 0,      0, 0,      0,    0, 1, 1, 'ha00,  'h0a);
        vecs[24] = mk(0, 0,      0, 0,      0, 0,      0,    0, 0, 1, 'ha00,  'h0a);
        vecs[25] = mk(0, 0,      1, 'h300,  0, 0,      'h5a, 1, 0, 1, 'ha00,  'h0a);
        vecs[26] = mk(1, 'h300,  0, 0,      0, 0,      0,    0, 1, 0, 0,      'hb4);

        idle_inputs();
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_output("reset_valid", d, 32'(v_o[d]), 32'h0);
            check_output("reset_pred", d, 32'(p_o[d]), 32'h0);
            check_output("reset_target", d, t_o[d], 32'h0);
            check_output("reset_ghr", d, 32'(g_o[d]), 32'h0);
        end
        #3 rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            req[0] = vecs[i].req; pc[0] = vecs[i].pc; upd[0] = vecs[i].upd;
            upc[0] = vecs[i].upc; tk[0] = vecs[i].tk; utgt[0] = vecs[i].tgt;
            ughr[0] = vecs[i].ughr; mis[0] = vecs[i].mis;
            apply_stimulus();
            check_output("tbl_valid", i, 32'(v_o[0]), 32'(vecs[i].ev));
            check_output("tbl_pred", i, 32'(p_o[0]), 32'(vecs[i].ep));
            check_output("tbl_target", i, t_o[0], vecs[i].et);
            check_output("tbl_ghr", i, 32'(g_o[0]), 32'(vecs[i].eg));
        end
        idle_inputs();

        // Gshare alternating branch: stimulus uses the bench's own expected snapshot.
        for (int it = 0; it < 28; it++) begin
            actual = (it % 2 == 0);
            req[1] = 1'b1; pc[1] = 32'h300;
            apply_stimulus();
            req[1] = 1'b0;
            pred_seen = e_pred[1];
            snap = 8'(e_ghr[1]);
            if (it >= 20) check_output("alt_pred", it, 32'(p_o[1]), 32'(actual));
            apply_stimulus();
            upd[1] = 1'b1; upc[1] = 32'h300; tk[1] = actual; utgt[1] = 32'h340;
            ughr[1] = snap; mis[1] = (pred_seen != actual);
            apply_stimulus();
            idle_inputs();
        end

        // Mispredict restore in the same cycle as a hitting result drops the shift.
        req[1] = 1'b1; pc[1] = 32'h300;
        apply_stimulus();
        idle_inputs();
        upd[1] = 1'b1; upc[1] = 32'h300; tk[1] = 1'b0; ughr[1] = 8'h0a; mis[1] = 1'b1;
        apply_stimulus();
        idle_inputs();
        req[1] = 1'b1; pc[1] = 32'h300;
        apply_stimulus();
        check_output("restore_ghr", 0, 32'(g_o[1]), 32'h4);
        idle_inputs();

        // Asynchronous reset while a result is being presented.
        req[0] = 1'b1; pc[0] = 32'h80;
        apply_stimulus();
        idle_inputs();
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_output("midrst_valid", d, 32'(v_o[d]), 32'h0);
            check_output("midrst_pred", d, 32'(p_o[d]), 32'h0);
            check_output("midrst_target", d, t_o[d], 32'h0);
            check_output("midrst_ghr", d, 32'(g_o[d]), 32'h0);
        end
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        req[0] = 1'b1; pc[0] = 32'h80;
        apply_stimulus();
        check_output("post_rst_pred", 0, 32'(p_o[0]), 32'h0);
        idle_inputs();

        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                req[d]  = ($urandom_range(0, 1) == 1);
                pc[d]   = (32'($urandom_range(0, 63)) << 2) + (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0);
                upd[d]  = ($urandom_range(0, 4) < 2);
                upc[d]  = (32'($urandom_range(0, 63)) << 2) + (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0);
                tk[d]   = ($urandom_range(0, 1) == 1);
                utgt[d] = $urandom & 32'hffff_fffc;
                ughr[d] = 8'($urandom) & 8'((32'd1 << hist_of[d]) - 32'd1);
                mis[d]  = ($urandom_range(0, 3) == 0);
            end
            apply_stimulus();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
